csa_pipe_adder: RTL and testbench
=================================

# csa_pipe_adder

Parametrised, pipelined carry-select adder with valid/ready flow control; the successor of the fixed 12-bit combinational carry-select adder. Operands of WIDTH bits are split into BLOCK-bit slices. Block 0 is a ripple slice. Every other slice computes both carry-in cases and selects on the incoming carry. Slices are grouped into STAGES register stages, so wide adds close timing in the datapath and arithmetic units that consume this block.

## Interface
- WIDTH, 32: operand and sum width; must be a multiple of BLOCK.
- BLOCK, 4: slice width in bits; NBLK = WIDTH/BLOCK.
- STAGES, 2: pipeline register stages; must divide NBLK; BPS = NBLK/STAGES slices per stage.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  operand beat present.
- o_ready  out  1  block accepts a beat this cycle.
- i_add_term1  in  WIDTH  addend A (unsigned / two's complement).
- i_add_term2  in  WIDTH  addend B.
- i_cin  in  1  carry into bit 0.
- o_valid  out  1  result beat present.
- i_ready  in  1  downstream accepts the result.
- o_sum  out  WIDTH  (A + B + cin) mod 2^WIDTH.
- o_cout  out  1  carry out of bit WIDTH-1.
- o_ovf  out  1  signed overflow; present only with CSA_PIPE_OVF_EN.

## Operation
- Stage s (0..STAGES-1) computes slices s·BPS .. s·BPS+BPS-1.
  - Stage 0's first slice ripples from i_cin.
  - Every other slice precomputes sum0/cout0 (carry 0) and sum1/cout1 (carry 1), then muxes on the carry from the previous slice.
  - The first slice of stage s>0 takes its carry from the stage s-1 register.
- Each stage register holds:
  - a valid bit;
  - the sum bits completed so far;
  - the boundary carry;
  - the still-unused upper operand bits, delayed alongside.
- Global-stall pipeline: advance = i_ready | ~o_valid. When advance=1, every stage register loads from its predecessor, and stage 0 loads the input beat qualified by i_valid. When advance=0, all stages hold.
- o_ready = advance & ~i_rst. A beat is accepted on i_valid & o_ready.
- Bubbles are not collapsed; an empty stage propagates valid=0.
- Result is delivered on o_valid & i_ready. o_sum/o_cout/o_ovf stay stable while o_valid=1 and i_ready=0.
- Arithmetic:
  - {o_cout, o_sum} = A + B + cin, exact, WIDTH+1 bits.
  - No saturation.
  - Unsigned and signed interpretation give identical o_sum.

## Timing
- Latency: STAGES cycles from acceptance to o_valid with no stall; each stall cycle adds one.
- Throughput: one beat per cycle while i_ready=1.
- Reset:
  - On i_rst=1 at an edge, all valid bits clear and all data registers clear: o_valid=0, o_sum=0, o_cout=0, o_ovf=0.
  - o_ready=0 while i_rst is high.
  - Reset mid-operation discards all in-flight beats; no partial result is emitted.
  - o_ready returns to 1 in the first cycle after i_rst deasserts.
- Simultaneous input accept and output pop when full: both occur and the pipe shifts by one. Back-to-back full throughput with no bubble is required.
- i_ready=0 with o_valid=0: the pipe still advances, so bubbles drain toward the output.
- Input data is sampled only at the accepting edge; it may change freely when i_valid=0 or o_ready=0.
- STAGES=1 with BLOCK=WIDTH degenerates to a single registered ripple adder; latency is 1.

## Configuration
- CSA_PIPE_OVF_EN defined:
  - o_ovf exists.
  - o_ovf = carry into bit WIDTH-1 XOR o_cout, registered with the final stage; same latency and stall behaviour as o_sum.
- CSA_PIPE_OVF_EN undefined: o_ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold i_rst 3 cycles with i_valid=1 -> o_ready=0, o_valid=0, o_sum=0, o_cout=0; o_ready=1 the cycle after release.
- Full carry chain (WIDTH=32, STAGES=2): A=32'hFFFF_FFFF, B=0, cin=1 -> after 2 cycles o_sum=0, o_cout=1.
- Streaming: 100 back-to-back random beats with i_ready=1 -> 100 results in order, each equal to the golden model, with no gaps.
- Backpressure: i_ready=0 for 5 cycles once o_valid=1 -> o_sum held stable, o_ready=0, no beat lost or duplicated after release.
- Overflow (with CSA_PIPE_OVF_EN): A=32'h7FFF_FFFF, B=1, cin=0 -> o_sum=32'h8000_0000, o_ovf=1, o_cout=0. A=32'h8000_0000, B=32'h8000_0000 -> o_sum=0, o_ovf=1, o_cout=1.
- Mid-flight reset: accept 2 beats, pulse i_rst one cycle -> no o_valid for those beats; next accepted beat 5+7+0 -> o_sum=12.

Source files
------------

// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined carry-select adder with valid/ready flow control.
// WIDTH-bit operands are cut into BLOCK-bit slices; slice 0 ripples from the
// carry-in, every other slice precomputes both carry cases and selects.
// Slices are spread evenly over STAGES register stages (global-stall pipe).
// Optional feature macro: CSA_PIPE_OVF_EN adds the registered o_ovf output.
module csa_pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef CSA_PIPE_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int unsigned NBLK = WIDTH / BLOCK;
    localparam int unsigned BPS  = NBLK / STAGES;
    localparam int unsigned SW   = BLOCK + 1;
    localparam int unsigned LAST = STAGES - 1;

    // Stage registers: valid, completed sum bits, boundary carry, delayed operands.
    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];

    // Stage sources (inputs for stage 0, previous register otherwise).
    logic             src_vld [STAGES];
    logic [WIDTH-1:0] src_sum [STAGES];
    logic             src_c   [STAGES];
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];

    // Stage results to be loaded on advance.
    logic [WIDTH-1:0] n_sum [STAGES];
    logic             n_c   [STAGES];

`ifdef CSA_PIPE_OVF_EN
    logic n_ovf;
    logic r_ovf;
`endif

    logic advance;
    logic unused_ops;

    // Global stall: the whole pipe moves unless a result is waiting on downstream.
    assign advance = i_ready | ~r_vld[LAST];
    assign o_ready = advance & ~i_rst;

    assign o_valid = r_vld[LAST];
    assign o_sum   = r_sum[LAST];
    assign o_cout  = r_c[LAST];
`ifdef CSA_PIPE_OVF_EN
    assign o_ovf   = r_ovf;
`endif

    // Final stage operand copies are fully consumed by the time they land.
    assign unused_ops = ^{r_a[LAST], r_b[LAST]};

    // Route each stage's source: stage 0 from the port, later stages from the prior register.
    always_comb begin
        for (int s = 0; s < int'(STAGES); s++) begin
            src_vld[s] = 1'b0;
            src_sum[s] = '0;
            src_c[s]   = 1'b0;
            src_a[s]   = '0;
            src_b[s]   = '0;
        end
        src_vld[0] = i_valid;
        src_sum[0] = '0;
        src_c[0]   = i_cin;
        src_a[0]   = i_add_term1;
        src_b[0]   = i_add_term2;
        for (int s = 1; s < int'(STAGES); s++) begin
            src_vld[s] = r_vld[s-1];
            src_sum[s] = r_sum[s-1];
            src_c[s]   = r_c[s-1];
            src_a[s]   = r_a[s-1];
            src_b[s]   = r_b[s-1];
        end
    end

    // Per-stage slice arithmetic: ripple slice 0, carry-select for all others.
    always_comb begin : p_slices
        logic [WIDTH-1:0] ss;
        logic             c;
        logic [SW-1:0]    t0;
        logic [SW-1:0]    t1;
        logic [SW-1:0]    t;
        int               idx;
        int               lo;
        ss  = '0;
        c   = 1'b0;
        t0  = '0;
        t1  = '0;
        t   = '0;
        idx = 0;
        lo  = 0;
`ifdef CSA_PIPE_OVF_EN
        n_ovf = 1'b0;
`endif
        for (int s = 0; s < int'(STAGES); s++) begin
            ss = src_sum[s];
            c  = src_c[s];
            for (int k = 0; k < int'(BPS); k++) begin
                idx = s * int'(BPS) + k;
                lo  = idx * int'(BLOCK);
                t0  = SW'(src_a[s][lo +: BLOCK]) + SW'(src_b[s][lo +: BLOCK]);
                t1  = t0 + SW'(1'b1);
                if (idx == 0) begin
                    t = t0 + SW'(c);
                end else begin
                    t = c ? t1 : t0;
                end
                ss[lo +: BLOCK] = t[BLOCK-1:0];
                c = t[BLOCK];
            end
            n_sum[s] = ss;
            n_c[s]   = c;
`ifdef CSA_PIPE_OVF_EN
            if (s == int'(LAST)) begin
                n_ovf = src_a[s][WIDTH-1] ^ src_b[s][WIDTH-1] ^ ss[WIDTH-1] ^ c;
            end
`endif
        end
    end

    // Stage registers: clear on reset, shift together on advance, hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                r_vld[s] <= 1'b0;
                r_sum[s] <= '0;
                r_c[s]   <= 1'b0;
                r_a[s]   <= '0;
                r_b[s]   <= '0;
            end
`ifdef CSA_PIPE_OVF_EN
            r_ovf <= 1'b0;
`endif
        end else if (advance) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                r_vld[s] <= src_vld[s];
                r_sum[s] <= n_sum[s];
                r_c[s]   <= n_c[s];
                r_a[s]   <= src_a[s];
                r_b[s]   <= src_b[s];
            end
`ifdef CSA_PIPE_OVF_EN
            r_ovf <= n_ovf;
`endif
        end
    end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb_csa_pipe_adder: directed table, streaming, backpressure, reset and random
// stall checks of csa_pipe_adder (WIDTH=32, BLOCK=4, STAGES=2) against an
// arithmetic reference model and an in-order scoreboard.
// Honours CSA_PIPE_OVF_EN when defined.
module tb_csa_pipe_adder;

    localparam int W   = 32;
    localparam int LAT = 2;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b1;
    logic         in_ready_o;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         ds_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CSA_PIPE_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int n_pop = 0;
    exp_t q[$];

    csa_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (in_valid),
        .o_ready     (in_ready_o),
        .i_add_term1 (a),
        .i_add_term2 (b),
        .i_cin       (cin),
        .o_valid     (out_valid),
        .i_ready     (ds_ready),
        .o_sum       (sum),
        .o_cout      (cout)
`ifdef CSA_PIPE_OVF_EN
        ,
        .o_ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t r;
        logic [W:0] t;
        t      = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: evaluated mid-cycle for what happens at the coming edge.
    logic         held = 1'b0;
    logic [W-1:0] held_sum;
    logic         held_cout;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_sum", 64'(sum), 64'(held_sum));
                check("hold_cout", 64'(cout), 64'(held_cout));
            end
            if (out_valid && ds_ready) begin
                if (q.size() == 0) begin
                    check("sb_unexpected", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_sum", 64'(sum), 64'(e.sum));
                    check("sb_cout", 64'(cout), 64'(e.cout));
`ifdef CSA_PIPE_OVF_EN
                    check("sb_ovf", 64'(ovf), 64'(e.ovf));
`endif
                end
                n_pop++;
            end
            held      = out_valid && !ds_ready;
            held_sum  = sum;
            held_cout = cout;
            if (in_valid && in_ready_o) q.push_back(model(a, b, cin));
        end
    end

    // Send one beat and wait for its result; checks latency and value.
    task automatic single(input string name, input vec_t v);
        int  lat;
        bit  seen;
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat  = 1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (out_valid) seen = 1;
            else begin
                step();
                lat++;
            end
        end
        if (!seen) begin
            check({name, "_timeout"}, 64'(0), 64'(1));
        end else begin
            check({name, "_lat"}, 64'(lat), 64'(LAT));
            check({name, "_sum"}, 64'(sum), 64'(v.sum));
            check({name, "_cout"}, 64'(cout), 64'(v.cout));
`ifdef CSA_PIPE_OVF_EN
            check({name, "_ovf"}, 64'(ovf), 64'(v.ovf));
`endif
        end
        step();
    endtask

    initial begin
        vec_t tbl[8];
        int   p0;
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[6] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
        tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};

        // Reset held with a beat offered: nothing accepted, outputs cleared.
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            step();
            check("rst_ready", 64'(in_ready_o), 64'(0));
            check("rst_valid", 64'(out_valid), 64'(0));
            check("rst_sum", 64'(sum), 64'(0));
            check("rst_cout", 64'(cout), 64'(0));
`ifdef CSA_PIPE_OVF_EN
            check("rst_ovf", 64'(ovf), 64'(0));
`endif
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rel_ready", 64'(in_ready_o), 64'(1));

        // Directed table.
        for (int i = 0; i < 8; i++) single($sformatf("vec%0d", i), tbl[i]);

        // Streaming: 100 back-to-back beats, results must be gap-free.
        p0 = n_pop;
        ds_ready = 1'b1;
        for (int c = 0; c < 102; c++) begin
            if (c < 100) begin
                in_valid = 1'b1;
                a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            step();
            check("stream_valid", 64'(out_valid), 64'((c >= 1 && c <= 100) ? 1 : 0));
        end
        check("stream_count", 64'(n_pop - p0), 64'(100));

        // Backpressure: stall 5 cycles with a result waiting.
        p0 = n_pop;
        in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0;
        step();
        a = $urandom; b = $urandom; cin = 1'b1;
        step();
        ds_ready = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("bp_ready", 64'(in_ready_o), 64'(0));
            step();
            check("bp_valid", 64'(out_valid), 64'(1));
        end
        ds_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 10 && (q.size() != 0 || out_valid); c++) step();
        step();
        check("bp_count", 64'(n_pop - p0), 64'(3));

        // Bubbles drain even while downstream is not ready.
        ds_ready = 1'b0;
        in_valid = 1'b1; a = 32'd100; b = 32'd23; cin = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        check("drain_valid", 64'(out_valid), 64'(1));
        check("drain_sum", 64'(sum), 64'(123));
        ds_ready = 1'b1;
        step();
        step();

        // Mid-flight reset: two accepted beats are discarded.
        ds_ready = 1'b0;
        in_valid = 1'b1; a = 32'd1; b = 32'd2; cin = 1'b0;
        step();
        a = 32'd3; b = 32'd4;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ds_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("mrst_valid", 64'(out_valid), 64'(0));
            step();
        end
        single("mrst_5p7", tbl[3]);

        // Random valid/ready traffic against the scoreboard.
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            ds_ready = ($urandom_range(0, 2) != 0);
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        ds_ready = 1'b1;
        for (int c = 0; c < 20 && (q.size() != 0 || out_valid); c++) step();
        step();
        check("final_empty", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
